// File: rtl/five_operand_accumulator_pkg.sv
// Shared constants and state type for the five-operand accumulator slice.
// Operand/sum widths are fixed by the 6-bit adder datapath; only the operand count varies.
package five_operand_accumulator_pkg;

  localparam int OPW                = 4;
  localparam int SUMW               = 7;
  localparam int N_OPERANDS_DEFAULT = 5;
  localparam int CNTW               = 3;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

endpackage

// File: rtl/six_bit_adder.sv
// Plain 6-bit ripple-carry adder shared by the accumulator datapath.
module six_bit_adder (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       cin,
  output logic [5:0] sum,
  output logic       cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < 6; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/five_operand_accumulator.sv
// Time-multiplexed N-operand accumulator: one operand per handshake through a single
// 6-bit adder, total presented on a valid/ready output with the carry folded into bit 6.
//
// state    | meaning
// ST_ACCUM | accepting operands, in_ready=1
// ST_DONE  | total held on out_sum, out_valid=1 until out_ready
module five_operand_accumulator
  import five_operand_accumulator_pkg::*;
#(
  parameter int N_OPERANDS = N_OPERANDS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [OPW-1:0]  in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [SUMW-1:0] out_sum,
  input  logic            out_ready
);

  state_e            state_q, state_d;
  logic [SUMW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]   count_q, count_d;

  logic [5:0]        add_sum;
  logic              add_cout;
  logic              accept;

  six_bit_adder u_adder (
    .a    (acc_q[5:0]),
    .b    ({2'b00, in_data}),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  // Outputs decode from state only, so neither handshake input reaches an output combinationally.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_sum   = acc_q;
    accept    = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          acc_d = {acc_q[6] | add_cout, add_sum};
          if (count_q == CNTW'(N_OPERANDS - 1)) begin
            state_d = ST_DONE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          count_d = '0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

endmodule
